// File: rtl/mos_pkg.sv
// Shared types and helpers for the switch-level MOS evaluation core.
//
// 4-state values are carried as two-bit codes so they survive synthesis:
//   2'b00 = logic 0, 2'b01 = logic 1, 2'b10 = high impedance, 2'b11 = unknown.
//
// Contents:
//   logic4_t            two-bit 4-state value
//   L4_0/L4_1/L4_Z/L4_X the four encodings
//   resolve2(a, b)      wired resolution of two drivers on one net
//   is_clash(v)         true when a resolved net carries an unknown value
package mos_pkg;

    typedef logic [1:0] logic4_t;

    localparam logic4_t L4_0 = 2'b00;
    localparam logic4_t L4_1 = 2'b01;
    localparam logic4_t L4_Z = 2'b10;
    localparam logic4_t L4_X = 2'b11;

    // Wired resolution of two drivers. Z is the identity element and X is
    // absorbing, so folding this over any number of channels starting from Z
    // gives the same answer regardless of channel order.
    function automatic logic4_t resolve2(input logic4_t a, input logic4_t b);
        logic4_t r;
        if (a == L4_Z) begin
            r = b;
        end else if (b == L4_Z) begin
            r = a;
        end else if ((a == L4_X) || (b == L4_X)) begin
            r = L4_X;
        end else if (a != b) begin
            r = L4_X;
        end else begin
            r = a;
        end
        return r;
    endfunction

    // A resolved net can only become X through an X driver or a 0/1 clash,
    // so an X on the bus is exactly the conflict condition.
    function automatic logic is_clash(input logic4_t v);
        return (v == L4_X);
    endfunction

endpackage

// File: rtl/mos_switch.sv
// One combinational MOS pass device (nmos or pmos) in 4-state encoding.
//
// Ports:
//   data     in  logic4_t  source terminal value
//   gate     in  logic4_t  gate terminal value
//   is_pmos  in  1         1 = pmos (conducts on gate 0), 0 = nmos (conducts on gate 1)
//   out      out logic4_t  drain value
//
// An unknown or floating gate means the device may or may not conduct. If the
// source floats the drain floats either way; otherwise the drain could be
// either the source level or Z, which without strength modelling collapses to X.
module mos_switch
    import mos_pkg::*;
(
    input  logic4_t data,
    input  logic4_t gate,
    input  logic    is_pmos,
    output logic4_t out
);

    logic conducting;
    logic blocking;

    always_comb begin
        conducting = 1'b0;
        blocking   = 1'b0;
        if (gate == L4_1) begin
            conducting = !is_pmos;
            blocking   = is_pmos;
        end else if (gate == L4_0) begin
            conducting = is_pmos;
            blocking   = !is_pmos;
        end
    end

    always_comb begin
        out = L4_X;
        if (conducting) begin
            out = data;
        end else if (blocking) begin
            out = L4_Z;
        end else if (data == L4_Z) begin
            out = L4_Z;
        end else begin
            out = L4_X;
        end
    end

endmodule

// File: rtl/mos_switch_array.sv
// Registered array of N MOS pass devices whose drains are also wired onto a
// single shared net.
//
// Parameters:
//   N       number of channels (1..32)
//   P_MASK  per-channel device type, bit i = 1 -> pmos, 0 -> nmos
//
// Ports:
//   clk         in   1    clock, all state changes on the rising edge
//   rst         in   1    synchronous active-high reset, dominates en
//   en          in   1    sample enable; outputs hold while low
//   data_i      in   2*N  4-state source per channel, channel i at [2i+1:2i]
//   gate_i      in   2*N  4-state gate per channel, same packing
//   ch_o        out  2*N  registered drain value per channel
//   bus_o       out  2    registered wired resolution of all channels
//   conflict_o  out  1    registered: bus is X from a clash or an X driver
//
// Latency is one cycle from a sample taken with en=1. Reset drives every
// output to the floating state and drops whatever was sampled alongside it.
module mos_switch_array
    import mos_pkg::*;
#(
    parameter int          N      = 4,
    parameter logic [N-1:0] P_MASK = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [2*N-1:0] data_i,
    input  logic [2*N-1:0] gate_i,
    output logic [2*N-1:0] ch_o,
    output logic [1:0]     bus_o,
    output logic           conflict_o
);

    logic4_t        ch_next [N];
    logic [2*N-1:0] ch_next_flat;
    logic4_t        bus_next;
    logic           conflict_next;

    logic [2*N-1:0] ch_reg;
    logic4_t        bus_reg;
    logic           conflict_reg;

    // One switch per channel, unpacked from the flat input buses.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_switch
            mos_switch u_switch (
                .data    (data_i[2*gi +: 2]),
                .gate    (gate_i[2*gi +: 2]),
                .is_pmos (P_MASK[gi]),
                .out     (ch_next[gi])
            );
            assign ch_next_flat[2*gi +: 2] = ch_next[gi];
        end
    endgenerate

    // Linear fold from Z; resolve2 is associative and commutative so the
    // channel order does not affect the result.
    always_comb begin
        bus_next = L4_Z;
        for (int i = 0; i < N; i++) begin
            bus_next = resolve2(bus_next, ch_next[i]);
        end
        conflict_next = is_clash(bus_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_reg       <= {N{L4_Z}};
            bus_reg      <= L4_Z;
            conflict_reg <= 1'b0;
        end else if (en) begin
            ch_reg       <= ch_next_flat;
            bus_reg      <= bus_next;
            conflict_reg <= conflict_next;
        end
    end

    assign ch_o       = ch_reg;
    assign bus_o      = bus_reg;
    assign conflict_o = conflict_reg;

endmodule

// File: tb/tb_mos_switch_array.sv
// Directed bench for mos_switch_array. Three instances share stimulus:
//   dut_n  : N=4, all nmos
//   dut_p  : N=4, channel 1 pmos
//   dut_1  : N=1, nmos, driven from channel 0 of the shared inputs
// Encoding per channel: 00=0 01=1 10=Z 11=X, channel 3 in the top bits.
module tb_mos_switch_array;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [7:0] data = 8'h00;
    logic [7:0] gate = 8'h00;

    logic [7:0] ch_n, ch_p;
    logic [1:0] bus_n, bus_p, ch_1, bus_1;
    logic       conf_n, conf_p, conf_1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mos_switch_array #(.N(4), .P_MASK(4'b0000)) dut_n (
        .clk(clk), .rst(rst), .en(en), .data_i(data), .gate_i(gate),
        .ch_o(ch_n), .bus_o(bus_n), .conflict_o(conf_n)
    );

    mos_switch_array #(.N(4), .P_MASK(4'b0010)) dut_p (
        .clk(clk), .rst(rst), .en(en), .data_i(data), .gate_i(gate),
        .ch_o(ch_p), .bus_o(bus_p), .conflict_o(conf_p)
    );

    mos_switch_array #(.N(1), .P_MASK(1'b0)) dut_1 (
        .clk(clk), .rst(rst), .en(en), .data_i(data[1:0]), .gate_i(gate[1:0]),
        .ch_o(ch_1), .bus_o(bus_1), .conflict_o(conf_1)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_n(input string tag, input logic [7:0] ch, input logic [1:0] bus, input logic conf);
        check({tag, " n.ch"},   ch_n, ch);
        check({tag, " n.bus"},  {6'b0, bus_n}, {6'b0, bus});
        check({tag, " n.conf"}, {7'b0, conf_n}, {7'b0, conf});
    endtask

    task automatic check_p(input string tag, input logic [7:0] ch, input logic [1:0] bus, input logic conf);
        check({tag, " p.ch"},   ch_p, ch);
        check({tag, " p.bus"},  {6'b0, bus_p}, {6'b0, bus});
        check({tag, " p.conf"}, {7'b0, conf_p}, {7'b0, conf});
    endtask

    task automatic check_1(input string tag, input logic [1:0] ch, input logic [1:0] bus, input logic conf);
        check({tag, " 1.ch"},   {6'b0, ch_1}, {6'b0, ch});
        check({tag, " 1.bus"},  {6'b0, bus_1}, {6'b0, bus});
        check({tag, " 1.conf"}, {7'b0, conf_1}, {7'b0, conf});
    endtask

    initial begin
        #1;

        // Reset state
        rst = 1'b1; en = 1'b0;
        tick();
        check_n("reset", 8'hAA, 2'b10, 1'b0);
        check_p("reset", 8'hAA, 2'b10, 1'b0);
        check_1("reset", 2'b10, 2'b10, 1'b0);
        $display("step reset: ch_n=%h bus_n=%b conf_n=%b", ch_n, bus_n, conf_n);

        // ch0 nmos on driving 1, others gate 0; pmos ch1 then conducts a 0
        rst = 1'b0; en = 1'b1;
        gate = 8'h01; data = 8'h01;
        tick();
        check_n("drive1", 8'hA9, 2'b01, 1'b0);
        check_p("drive1", 8'hA1, 2'b11, 1'b1);
        check_1("drive1", 2'b01, 2'b01, 1'b0);
        $display("step drive1: ch_n=%h bus_n=%b ch_p=%h bus_p=%b", ch_n, bus_n, ch_p, bus_p);

        // ch0 gate X with data 1 -> X
        gate = 8'h03; data = 8'h01;
        tick();
        check_n("gateX", 8'hAB, 2'b11, 1'b1);
        check_p("gateX", 8'hA3, 2'b11, 1'b1);
        check_1("gateX", 2'b11, 2'b11, 1'b1);
        $display("step gateX: ch_n=%h bus_n=%b ch_1=%b conf_1=%b", ch_n, bus_n, ch_1, conf_1);

        // ch0 gate X with data Z -> Z
        gate = 8'h03; data = 8'h02;
        tick();
        check_n("gateXdZ", 8'hAA, 2'b10, 1'b0);
        check_p("gateXdZ", 8'hA2, 2'b00, 1'b0);
        check_1("gateXdZ", 2'b10, 2'b10, 1'b0);
        $display("step gateXdZ: ch_n=%h bus_n=%b ch_p=%h bus_p=%b", ch_n, bus_n, ch_p, bus_p);

        // en low: inputs change, outputs hold for two cycles
        en = 1'b0; gate = 8'h55; data = 8'h00;
        tick();
        check_n("hold1", 8'hAA, 2'b10, 1'b0);
        check_p("hold1", 8'hA2, 2'b00, 1'b0);
        tick();
        check_n("hold2", 8'hAA, 2'b10, 1'b0);
        check_1("hold2", 2'b10, 2'b10, 1'b0);
        $display("step hold: ch_n=%h ch_p=%h", ch_n, ch_p);

        // en back high: update one cycle later; pmos ch1 now off
        en = 1'b1;
        tick();
        check_n("resume", 8'h00, 2'b00, 1'b0);
        check_p("resume", 8'h08, 2'b00, 1'b0);
        check_1("resume", 2'b00, 2'b00, 1'b0);
        $display("step resume: ch_n=%h ch_p=%h", ch_n, ch_p);

        // all nmos on, data 0/1/Z/X passed through; X driver and clash
        gate = 8'h55; data = 8'hE4;
        tick();
        check_n("pass", 8'hE4, 2'b11, 1'b1);
        check_p("pass", 8'hE8, 2'b11, 1'b1);
        $display("step pass: ch_n=%h ch_p=%h", ch_n, ch_p);

        // floating gates: data Z -> Z, driven data -> X
        gate = 8'hAA; data = 8'h26;
        tick();
        check_n("gateZ", 8'hEE, 2'b11, 1'b1);
        check_p("gateZ", 8'hEE, 2'b11, 1'b1);
        check_1("gateZ", 2'b10, 2'b10, 1'b0);
        $display("step gateZ: ch_n=%h ch_1=%b", ch_n, ch_1);

        // agreeing drivers of 1 resolve to 1 with no conflict
        gate = 8'h55; data = 8'h55;
        tick();
        check_n("agree", 8'h55, 2'b01, 1'b0);
        check_p("agree", 8'h59, 2'b01, 1'b0);
        check_1("agree", 2'b01, 2'b01, 1'b0);
        $display("step agree: ch_n=%h bus_n=%b ch_p=%h", ch_n, bus_n, ch_p);

        // reset with en=1 and active drivers wins; then the sample is not replayed
        gate = 8'h55; data = 8'h00; rst = 1'b1; en = 1'b1;
        tick();
        check_n("rst_en", 8'hAA, 2'b10, 1'b0);
        check_p("rst_en", 8'hAA, 2'b10, 1'b0);
        check_1("rst_en", 2'b10, 2'b10, 1'b0);
        rst = 1'b0; en = 1'b0;
        tick();
        check_n("rst_after", 8'hAA, 2'b10, 1'b0);
        $display("step rst_en: ch_n=%h bus_n=%b conf_n=%b", ch_n, bus_n, conf_n);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish by 100000");
        $fatal(1, "timeout");
    end

endmodule
